acc_core: RTL
=============

# acc_core

Parametrised, single-clock accumulator CPU core; successor to the 8-bit GCore datapath. Replaces the multi-phase gated-clock scheme with one clock and an explicit phase state machine (FETCH/MEM/EXEC). Holds an internal program RAM with a host load port, an internal data RAM, and run, single-step and halt control. Exposes the accumulator, PC and flags for board-level observation.

## Interface
- DW, 8: data and accumulator width (≥4)
- IAW, 8: program address width; program RAM depth 2^IAW
- DAW, 4: data address width / operand field width; data RAM depth 2^DAW
- clk  in  1  system clock; all state on rising edge
- rst  in  1  asynchronous, active-low reset
- run  in  1  level: 1 = free-run instructions
- step  in  1  one-cycle pulse: execute exactly one instruction (honoured in IDLE only)
- load_en  in  1  program RAM write strobe (honoured in IDLE/HALT only)
- load_addr  in  IAW  program write address
- load_data  in  4+DAW  instruction word {op[3:0], operand[DAW-1:0]}
- acc_out  out  DW  accumulator
- pc_out  out  IAW  program counter
- zero_out  out  1  Z flag
- carry_out  out  1  C flag
- busy  out  1  1 in FETCH/MEM/EXEC
- halted  out  1  1 in HALT
- instr_done  out  1  one-cycle pulse on the cycle after EXEC

## Operation
- States: IDLE, FETCH, MEM, EXEC, HALT. Three cycles per instruction.
- IDLE: run=1 or step=1 → FETCH; latch step_mode=~run.
- FETCH: ir ← prog[pc]. MEM: mdr ← data[ir.operand]. EXEC: execute; pc ← pc+1 mod 2^IAW unless jump taken.
- After EXEC: step_mode or run=0 → IDLE; else → FETCH. HLT → HALT.
- HALT: held while run=1; run=0 → IDLE. step ignored.
- Opcodes (operand m / imm = ir[DAW-1:0]):
  - 0 NOP; 1 LDA acc←data[m]; 2 STA data[m]←acc; 3 LDI acc←zero-ext imm
  - 4 ADD acc←acc+data[m], C=carry out; 5 SUB acc←acc−data[m], C=borrow
  - 6 AND, 7 OR, 8 XOR with data[m]
  - 9 SHL acc←acc<<imm (imm≥DW gives 0); A JMP pc←data[m][IAW-1:0] (zero-ext if DW<IAW)
  - B BZ: as JMP if Z=1, else pc+1; C HLT; D–F NOP
- Z ← (new acc==0) on every acc write (1,3–9); unchanged otherwise. C changes only on 4/5.
- All arithmetic modulo 2^DW; pc wraps 2^IAW−1 → 0.
- load_en in FETCH/MEM/EXEC ignored (no write). Loads in IDLE/HALT write prog[load_addr] in one cycle.

## Timing
- Reset (async, rst=0): state IDLE, pc=0, acc=0, Z=0, C=0, ir=0, mdr=0, data RAM all 0, busy=0, halted=0, instr_done=0. Program RAM not cleared. Reset mid-instruction aborts it with no partial STA write.
- Latency: run rising in IDLE → busy=1 next cycle; acc/pc/flags/STA update on the EXEC edge; instr_done high the following cycle.
- Back-to-back: instr_done every 3 cycles while run=1.
- run falling mid-instruction: instruction completes, then IDLE; pc points to next instruction.
- step while run=1: no effect. step held high: one instruction per IDLE entry.
- STA then LDA same address: LDA sees the stored value (write in EXEC precedes next MEM).
- HLT: pc = HLT address+1; halted=1 from the cycle after EXEC.

## Test plan
- Reset: drive rst=0 mid-ADD → all outputs 0, state IDLE; data RAM reads 0.
- Load program {LDI 5, STA 2, ADD 2, HLT}, run=1 → acc_out=10, Z=0, C=0, halted=1, pc_out=4, instr_done pulses 4 times spaced 3 cycles.
- Carry/zero (DW=8): data[1]=0xFF via LDI 15/SHL 4/ … ; acc=0x01 ADD 0xFF → acc=0, Z=1, C=1; SUB 1 from 0 → acc=0xFF, C=1, Z=0.
- Branch: data[3]=0x10; LDI 0, BZ 3 → pc=0x10; LDI 1, BZ 3 → pc falls through (+1).
- Single-step: run=0, step pulse → exactly one instruction, instr_done once, back to IDLE; load_en during busy leaves prog unchanged.
- Wrap and param: IAW=4, NOP-filled program, run 16 instructions → pc_out returns to 0; DW=16 ADD 0xFFFF+1 → 0, C=1.

Source files
------------

// File: rtl/acc_core.sv
// acc_core: single-clock accumulator CPU sequenced by an IDLE/FETCH/MEM/EXEC/HALT
// phase machine, with internal program RAM (host-loadable) and data RAM.
module acc_core #(
    parameter int DW  = 8,
    parameter int IAW = 8,
    parameter int DAW = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             run,
    input  logic             step,
    input  logic             load_en,
    input  logic [IAW-1:0]   load_addr,
    input  logic [DAW+3:0]   load_data,
    output logic [DW-1:0]    acc_out,
    output logic [IAW-1:0]   pc_out,
    output logic             zero_out,
    output logic             carry_out,
    output logic             busy,
    output logic             halted,
    output logic             instr_done
);

    localparam int IW     = DAW + 4;
    localparam int PDEPTH = 1 << IAW;
    localparam int DDEPTH = 1 << DAW;
    localparam int JW     = (DW < IAW) ? DW : IAW;
    localparam int KW     = (DAW < DW) ? DAW : DW;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_FETCH = 3'd1;
    localparam logic [2:0] S_MEM   = 3'd2;
    localparam logic [2:0] S_EXEC  = 3'd3;
    localparam logic [2:0] S_HALT  = 3'd4;

    localparam logic [3:0] OP_LDA = 4'h1;
    localparam logic [3:0] OP_STA = 4'h2;
    localparam logic [3:0] OP_LDI = 4'h3;
    localparam logic [3:0] OP_ADD = 4'h4;
    localparam logic [3:0] OP_SUB = 4'h5;
    localparam logic [3:0] OP_AND = 4'h6;
    localparam logic [3:0] OP_OR  = 4'h7;
    localparam logic [3:0] OP_XOR = 4'h8;
    localparam logic [3:0] OP_SHL = 4'h9;
    localparam logic [3:0] OP_JMP = 4'hA;
    localparam logic [3:0] OP_BZ  = 4'hB;
    localparam logic [3:0] OP_HLT = 4'hC;

    logic [2:0]     state;
    logic [IAW-1:0] pc;
    logic [DW-1:0]  acc;
    logic [DW-1:0]  mdr;
    logic [IW-1:0]  ir;
    logic           zf;
    logic           cf;
    logic           step_mode;

    logic [IW-1:0]  prog_mem [0:PDEPTH-1];
    logic [DW-1:0]  data_mem [0:DDEPTH-1];

    logic [3:0]     opcode;
    logic [DAW-1:0] operand;
    logic [DW-1:0]  imm_ext;
    logic [IAW-1:0] jump_target;
    logic [IAW-1:0] pc_new;
    logic [DW-1:0]  acc_new;
    logic           acc_wr;
    logic           carry_new;
    logic [DW:0]    sum;
    logic [DW:0]    diff;
    logic           load_ok;

    assign opcode  = ir[IW-1:DAW];
    assign operand = ir[DAW-1:0];
    assign sum     = {1'b0, acc} + {1'b0, mdr};
    assign diff    = {1'b0, acc} - {1'b0, mdr};
    assign load_ok = load_en && (state == S_IDLE || state == S_HALT);

    // Immediate and jump target are zero-extended or truncated to fit whichever width is smaller.
    always_comb begin
        imm_ext              = '0;
        imm_ext[KW-1:0]      = operand[KW-1:0];
        jump_target          = '0;
        jump_target[JW-1:0]  = mdr[JW-1:0];
    end

    always_comb begin
        acc_new   = acc;
        acc_wr    = 1'b0;
        carry_new = cf;
        pc_new    = pc + IAW'(1);
        case (opcode)
            OP_LDA: begin acc_new = mdr;           acc_wr = 1'b1; end
            OP_LDI: begin acc_new = imm_ext;       acc_wr = 1'b1; end
            OP_ADD: begin
                acc_new   = sum[DW-1:0];
                carry_new = sum[DW];
                acc_wr    = 1'b1;
            end
            OP_SUB: begin
                acc_new   = diff[DW-1:0];
                carry_new = diff[DW];
                acc_wr    = 1'b1;
            end
            OP_AND: begin acc_new = acc & mdr;     acc_wr = 1'b1; end
            OP_OR:  begin acc_new = acc | mdr;     acc_wr = 1'b1; end
            OP_XOR: begin acc_new = acc ^ mdr;     acc_wr = 1'b1; end
            // A shift by DW or more naturally yields zero.
            OP_SHL: begin acc_new = acc << operand; acc_wr = 1'b1; end
            OP_JMP: pc_new = jump_target;
            OP_BZ:  if (zf) pc_new = jump_target;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= S_IDLE;
            pc         <= '0;
            acc        <= '0;
            mdr        <= '0;
            ir         <= '0;
            zf         <= 1'b0;
            cf         <= 1'b0;
            step_mode  <= 1'b0;
            instr_done <= 1'b0;
        end else begin
            instr_done <= (state == S_EXEC);
            case (state)
                S_IDLE: begin
                    if (run || step) begin
                        state     <= S_FETCH;
                        step_mode <= ~run;
                    end
                end
                S_FETCH: begin
                    ir    <= prog_mem[pc];
                    state <= S_MEM;
                end
                S_MEM: begin
                    mdr   <= data_mem[operand];
                    state <= S_EXEC;
                end
                S_EXEC: begin
                    pc <= pc_new;
                    cf <= carry_new;
                    if (acc_wr) begin
                        acc <= acc_new;
                        zf  <= (acc_new == '0);
                    end
                    if (opcode == OP_HLT)
                        state <= S_HALT;
                    else if (step_mode || !run)
                        state <= S_IDLE;
                    else
                        state <= S_FETCH;
                end
                S_HALT: begin
                    if (!run) state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // STA commits on the EXEC edge, so a following instruction's MEM phase sees it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            data_mem <= '{default: '0};
        else if (state == S_EXEC && opcode == OP_STA)
            data_mem[operand] <= acc;
    end

    always_ff @(posedge clk) begin
        if (load_ok) prog_mem[load_addr] <= load_data;
    end

    assign acc_out   = acc;
    assign pc_out    = pc;
    assign zero_out  = zf;
    assign carry_out = cf;
    assign busy      = (state == S_FETCH) || (state == S_MEM) || (state == S_EXEC);
    assign halted    = (state == S_HALT);

endmodule
